// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_ctrl
// Description : Run/stop/set sequencer between button debouncers and the
//               mm:ss counter; edge detect, FSM, inc auto-repeat.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int REPEAT_DELAY_CYC = 50_000_000,
    parameter int REPEAT_RATE_CYC  = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_lvl,
    input  logic       stop_lvl,
    input  logic       softrst_lvl,
    input  logic       inc_min_lvl,
    input  logic       inc_sec_lvl,
    input  logic       inc_sw,
    input  logic       mode_sw,
    input  logic       tick,
    input  logic       cnt_zero,
    input  logic       cnt_max,
    output logic       cnt_en,
    output logic       cnt_down,
    output logic       cnt_clr,
    output logic       inc_min_p,
    output logic       inc_sec_p,
    output logic [1:0] state,
    output logic       expired
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_PAUSE   = 2'd2;
    localparam logic [1:0] S_EXPIRED = 2'd3;

    localparam int c_CNT_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ?
                               REPEAT_DELAY_CYC : REPEAT_RATE_CYC;
    localparam int c_CW      = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CW-1:0] c_DELAY = c_CW'(REPEAT_DELAY_CYC);
    localparam logic [c_CW-1:0] c_RATE  = c_CW'(REPEAT_RATE_CYC);
    localparam logic [c_CW-1:0] c_ONE   = {{(c_CW-1){1'b0}}, 1'b1};

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_mode_q;
    logic       r_cnt_en;
    logic       r_cnt_clr;
    logic       r_expired;
    logic       r_inc_min_p;
    logic       r_inc_sec_p;

    logic       r_start_q;
    logic       r_stop_q;
    logic       r_softrst_q;
    logic [1:0] r_inc_q;

    logic       w_start_rise;
    logic       w_stop_rise;
    logic       w_softrst_rise;
    logic [1:0] w_inc_lvl;
    logic [1:0] w_inc_rise;
    logic [1:0] w_inc_fire;
    logic       w_start_ok;
    logic       w_inc_ok;
    logic       w_cnt_block;

    // Index 0 = seconds button, index 1 = minutes button.
    assign w_inc_lvl      = {inc_min_lvl, inc_sec_lvl};
    assign w_start_rise   = start_lvl   & ~r_start_q;
    assign w_stop_rise    = stop_lvl    & ~r_stop_q;
    assign w_softrst_rise = softrst_lvl & ~r_softrst_q;
    assign w_inc_rise     = w_inc_lvl   & ~r_inc_q;

    // A timer sitting at 00:00 has nothing to count down, so start is refused.
    assign w_start_ok  = ~(r_mode_q & cnt_zero);
    assign w_cnt_block = r_mode_q ? cnt_zero : cnt_max;

    // Inc buttons lose to any control button pressed in the same cycle.
    assign w_inc_ok = ((r_state == S_IDLE) || (r_state == S_PAUSE)) &&
                      !w_softrst_rise && !w_stop_rise && !w_start_rise;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_q   <= 1'b0;
            r_stop_q    <= 1'b0;
            r_softrst_q <= 1'b0;
            r_inc_q     <= 2'b00;
        end else begin
            r_start_q   <= start_lvl;
            r_stop_q    <= stop_lvl;
            r_softrst_q <= softrst_lvl;
            r_inc_q     <= w_inc_lvl;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_softrst_rise && w_start_rise && w_start_ok)
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (w_softrst_rise)
                    w_state_nxt = S_IDLE;
                else if (w_stop_rise)
                    w_state_nxt = S_PAUSE;
                else if (r_mode_q && cnt_zero)
                    w_state_nxt = S_EXPIRED;
                else if (!r_mode_q && tick && cnt_max)
                    w_state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_softrst_rise)
                    w_state_nxt = S_IDLE;
                else if (w_start_rise && w_start_ok)
                    w_state_nxt = S_RUN;
            end
            S_EXPIRED: begin
                if (w_softrst_rise || w_stop_rise || w_start_rise)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mode_q    <= 1'b0;
            r_cnt_en    <= 1'b0;
            r_cnt_clr   <= 1'b0;
            r_expired   <= 1'b0;
            r_inc_min_p <= 1'b0;
            r_inc_sec_p <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            if (r_state == S_IDLE)
                r_mode_q <= mode_sw;
            r_cnt_en    <= (r_state == S_RUN) && tick && !w_softrst_rise && !w_cnt_block;
            r_cnt_clr   <= w_softrst_rise;
            r_expired   <= (w_state_nxt == S_EXPIRED);
            r_inc_min_p <= w_inc_fire[1];
            r_inc_sec_p <= w_inc_fire[0];
        end
    end

    // Per-button repeat timer: r_cnt counts cycles since the last pulse,
    // r_arm selects the initial delay or the steady repeat interval.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rep
            logic [c_CW-1:0] r_cnt;
            logic            r_arm;
            logic            w_hit;

            assign w_hit = (r_cnt != '0) && (r_cnt == (r_arm ? c_RATE : c_DELAY));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_arm <= 1'b0;
                end else if (!w_inc_ok || !w_inc_lvl[gi] || !inc_sw) begin
                    r_cnt <= '0;
                    r_arm <= 1'b0;
                end else if (w_inc_rise[gi]) begin
                    r_cnt <= c_ONE;
                    r_arm <= 1'b0;
                end else if (w_hit) begin
                    r_cnt <= c_ONE;
                    r_arm <= 1'b1;
                end else if (r_cnt != '0) begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end

            assign w_inc_fire[gi] = w_inc_ok &&
                                    (w_inc_rise[gi] || (inc_sw && w_inc_lvl[gi] && w_hit));
        end
    endgenerate

    assign cnt_en    = r_cnt_en;
    assign cnt_down  = r_mode_q;
    assign cnt_clr   = r_cnt_clr;
    assign inc_min_p = r_inc_min_p;
    assign inc_sec_p = r_inc_sec_p;
    assign state     = r_state;
    assign expired   = r_expired;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_ctrl
// Description : Scoreboard bench for stopwatch_ctrl with directed stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_EXP   = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_lvl = 1'b0, stop_lvl = 1'b0, softrst_lvl = 1'b0;
    logic       inc_min_lvl = 1'b0, inc_sec_lvl = 1'b0;
    logic       inc_sw = 1'b0, mode_sw = 1'b0, tick = 1'b0;
    logic       cnt_zero = 1'b0, cnt_max = 1'b0;
    logic       cnt_en, cnt_down, cnt_clr, inc_min_p, inc_sec_p, expired;
    logic [1:0] state;

    stopwatch_ctrl #(
        .REPEAT_DELAY_CYC(8),
        .REPEAT_RATE_CYC (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_lvl  (start_lvl),
        .stop_lvl   (stop_lvl),
        .softrst_lvl(softrst_lvl),
        .inc_min_lvl(inc_min_lvl),
        .inc_sec_lvl(inc_sec_lvl),
        .inc_sw     (inc_sw),
        .mode_sw    (mode_sw),
        .tick       (tick),
        .cnt_zero   (cnt_zero),
        .cnt_max    (cnt_max),
        .cnt_en     (cnt_en),
        .cnt_down   (cnt_down),
        .cnt_clr    (cnt_clr),
        .inc_min_p  (inc_min_p),
        .inc_sec_p  (inc_sec_p),
        .state      (state),
        .expired    (expired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] v;
        string      name;
    } ev_t;

    ev_t        sb[$];
    int         total = 0;
    int         bad   = 0;
    bit         mon_en = 1'b0;
    logic [7:0] m_cur, m_prev;
    bit         m_ev;

    // {state, expired, cnt_down, cnt_en, cnt_clr, inc_min_p, inc_sec_p}
    function automatic logic [7:0] outs();
        return {state, expired, cnt_down, cnt_en, cnt_clr, inc_min_p, inc_sec_p};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // p = {cnt_en, cnt_clr, inc_min_p, inc_sec_p}
    task automatic ev(input string name, input int dc, input logic [1:0] st,
                      input logic ex, input logic dn, input logic [3:0] p);
        ev_t e;
        e.cyc  = cyc + dc;
        e.v    = {st, ex, dn, p};
        e.name = name;
        sb.push_back(e);
    endtask

    // An output event is any pulse high or any change of state/expired/cnt_down.
    always @(negedge clk) begin
        if (mon_en) begin
            m_cur  = outs();
            m_ev   = (m_cur[3:0] != 4'b0000) || (m_cur[7:4] != m_prev[7:4]);
            m_prev = m_cur;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: no output event at cyc %0d, want %b", sb[0].name, sb[0].cyc, sb[0].v);
                sb.delete(0);
            end
            if (m_ev) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_event cyc %0d: got %b, want none", cyc, m_cur);
                end else if (sb[0].cyc != cyc) begin
                    bad++;
                    $display("FAIL unexpected_event cyc %0d: got %b, want none before %s at cyc %0d",
                             cyc, m_cur, sb[0].name, sb[0].cyc);
                end else begin
                    if (m_cur !== sb[0].v) begin
                        bad++;
                        $display("FAIL %s cyc %0d: got %b, want %b", sb[0].name, cyc, m_cur, sb[0].v);
                    end
                    sb.delete(0);
                end
            end
        end
    end

    initial begin
        step(3);
        rst = 1'b0;
        total++;
        if (outs() !== 8'h00) begin
            bad++;
            $display("FAIL reset_state: got %b, want 00000000", outs());
        end
        m_prev = outs();
        mon_en = 1'b1;

        // Stopwatch: start, tick, stop, ignored tick, restart, soft reset.
        start_lvl = 1'b1; ev("start_run", 1, ST_RUN, 0, 0, 4'b0000);
        step(1); start_lvl = 1'b0; step(1);
        tick = 1'b1; ev("tick_en", 1, ST_RUN, 0, 0, 4'b1000);
        step(1); tick = 1'b0; step(2);
        stop_lvl = 1'b1; ev("stop_pause", 1, ST_PAUSE, 0, 0, 4'b0000);
        step(1); stop_lvl = 1'b0; step(1);
        tick = 1'b1; step(1); tick = 1'b0; step(2);
        start_lvl = 1'b1; ev("pause_start", 1, ST_RUN, 0, 0, 4'b0000);
        step(1); start_lvl = 1'b0; step(1);
        softrst_lvl = 1'b1; ev("softrst_clr", 1, ST_IDLE, 0, 0, 4'b0100);
        step(1); softrst_lvl = 1'b0; step(2);

        // Timer mode: zero check on start, direction latched in IDLE only.
        mode_sw = 1'b1; ev("mode_latch", 1, ST_IDLE, 0, 1, 4'b0000);
        step(2);
        cnt_zero = 1'b1; start_lvl = 1'b1;
        step(1); start_lvl = 1'b0; step(1);
        cnt_zero = 1'b0; step(1);
        start_lvl = 1'b1; ev("timer_start", 1, ST_RUN, 0, 1, 4'b0000);
        step(1); start_lvl = 1'b0; step(1);
        mode_sw = 1'b0; step(2);
        tick = 1'b1; ev("timer_tick", 1, ST_RUN, 0, 1, 4'b1000);
        step(1); tick = 1'b0; step(1);

        // Expiry, ticks masked, stop returns to IDLE which relatches mode.
        cnt_zero = 1'b1; ev("expire", 1, ST_EXP, 1, 1, 4'b0000);
        step(1);
        tick = 1'b1; step(1); tick = 1'b0; step(2);
        stop_lvl = 1'b1;
        ev("exp_stop", 1, ST_IDLE, 0, 1, 4'b0000);
        ev("mode_relatch", 2, ST_IDLE, 0, 0, 4'b0000);
        step(1); stop_lvl = 1'b0; cnt_zero = 1'b0; step(3);

        // Auto-repeat on a 20-cycle hold in IDLE.
        inc_sw = 1'b1; inc_sec_lvl = 1'b1;
        ev("rep_rise", 1,  ST_IDLE, 0, 0, 4'b0001);
        ev("rep_dly",  9,  ST_IDLE, 0, 0, 4'b0001);
        ev("rep_r1",   13, ST_IDLE, 0, 0, 4'b0001);
        ev("rep_r2",   17, ST_IDLE, 0, 0, 4'b0001);
        step(20); inc_sec_lvl = 1'b0; step(3);
        inc_sw = 1'b0; inc_sec_lvl = 1'b1;
        ev("norep_rise", 1, ST_IDLE, 0, 0, 4'b0001);
        step(20); inc_sec_lvl = 1'b0; step(3);
        inc_sec_lvl = 1'b1; inc_min_lvl = 1'b1;
        ev("both_inc", 1, ST_IDLE, 0, 0, 4'b0011);
        step(1); inc_sec_lvl = 1'b0; inc_min_lvl = 1'b0; step(2);

        // Inc ignored in RUN.
        start_lvl = 1'b1; ev("run_for_inc", 1, ST_RUN, 0, 0, 4'b0000);
        step(1); start_lvl = 1'b0; step(1);
        inc_sw = 1'b1; inc_sec_lvl = 1'b1;
        step(20); inc_sec_lvl = 1'b0; step(3);

        // Simultaneous softrst+stop+start: softrst wins.
        softrst_lvl = 1'b1; stop_lvl = 1'b1; start_lvl = 1'b1;
        ev("all_ctrl", 1, ST_IDLE, 0, 0, 4'b0100);
        step(1); softrst_lvl = 1'b0; stop_lvl = 1'b0; start_lvl = 1'b0; step(2);

        // Stopwatch saturation, inc in PAUSE, softrst beats tick.
        start_lvl = 1'b1; ev("run_for_max", 1, ST_RUN, 0, 0, 4'b0000);
        step(1); start_lvl = 1'b0; step(1);
        cnt_max = 1'b1; tick = 1'b1; ev("max_sat", 1, ST_PAUSE, 0, 0, 4'b0000);
        step(1); tick = 1'b0; cnt_max = 1'b0; step(2);
        inc_sw = 1'b0; inc_min_lvl = 1'b1; ev("pause_inc_min", 1, ST_PAUSE, 0, 0, 4'b0010);
        step(1); inc_min_lvl = 1'b0; step(2);
        start_lvl = 1'b1; ev("pause_restart", 1, ST_RUN, 0, 0, 4'b0000);
        step(1); start_lvl = 1'b0; step(1);
        softrst_lvl = 1'b1; tick = 1'b1; ev("softrst_tick", 1, ST_IDLE, 0, 0, 4'b0100);
        step(1); softrst_lvl = 1'b0; tick = 1'b0; step(5);

        mon_en = 1'b0;
        while (sb.size() > 0) begin
            total++;
            bad++;
            $display("FAIL %s: never observed, want %b at cyc %0d", sb[0].name, sb[0].v, sb[0].cyc);
            sb.delete(0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
